// File: rtl/board_io_pkg.sv
// Shared types for the board I/O multiplexer: per-channel output mode encoding.
package board_io_pkg;

    localparam int unsigned ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        ModeGpo   = 2'd0,
        ModePwm   = 2'd1,
        ModeBlink = 2'd2,
        ModeOff   = 2'd3
    } io_mode_e;

endpackage

// File: rtl/io_debounce.sv
// One board input: 2-flop synchroniser, saturating debounce counter and rising-edge pulse.
module io_debounce #(
    parameter int unsigned DebounceCycles = 50000
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o
);

    localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            db_q, db_d;
    logic            rise_q, rise_d;

    // Any agreement with the accepted level restarts the stability window.
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        if (sync_q[1] == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            db_d   = sync_q[1];
            rise_d = sync_q[1];
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/board_io_mux.sv
// Board pin multiplexer: per-channel source select (GPO/PWM/BLINK/OFF) with registered
// pin drive, a shared blink generator, and debounced board inputs.
module board_io_mux
    import board_io_pkg::*;
#(
    parameter int unsigned NumOut         = 20,
    parameter int unsigned NumIn          = 4,
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned BlinkPeriod    = 25000000
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_sys_ni,
    input  logic [NumOut-1:0]         gp_i,
    input  logic [NumOut-1:0]         pwm_i,
    input  logic                      cfg_we_i,
    input  logic [$clog2(NumOut)-1:0] cfg_idx_i,
    input  logic [ModeW-1:0]          cfg_mode_i,
    output logic [NumOut-1:0]         pin_o,
    input  logic [NumIn-1:0]          in_raw_i,
    output logic [NumIn-1:0]          in_db_o,
    output logic [NumIn-1:0]          in_rise_o
);

    localparam int unsigned BlinkW = (BlinkPeriod > 1) ? $clog2(BlinkPeriod) : 1;
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BlinkPeriod - 1);

    io_mode_e          mode_q [NumOut];
    io_mode_e          mode_d [NumOut];
    logic [NumOut-1:0] pin_q, pin_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic              cfg_hit;

    // Out-of-range channel indices are dropped without touching any mode.
    assign cfg_hit = cfg_we_i && (32'(cfg_idx_i) < NumOut);

    always_comb begin
        for (int n = 0; n < NumOut; n++) begin
            mode_d[n] = mode_q[n];
        end
        if (cfg_hit) begin
            mode_d[cfg_idx_i] = io_mode_e'(cfg_mode_i);
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
        blink_d     = blink_q;
        if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_comb begin
        pin_d = '0;
        for (int n = 0; n < NumOut; n++) begin
            unique case (mode_q[n])
                ModeGpo:   pin_d[n] = gp_i[n];
                ModePwm:   pin_d[n] = pwm_i[n];
                ModeBlink: pin_d[n] = blink_q;
                default:   pin_d[n] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            for (int n = 0; n < NumOut; n++) begin
                mode_q[n] <= ModeGpo;
            end
            pin_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            for (int n = 0; n < NumOut; n++) begin
                mode_q[n] <= mode_d[n];
            end
            pin_q       <= pin_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign pin_o = pin_q;

    for (genvar i = 0; i < NumIn; i++) begin : g_in
        io_debounce #(
            .DebounceCycles (DebounceCycles)
        ) u_debounce (
            .clk_sys_i  (clk_sys_i),
            .rst_sys_ni (rst_sys_ni),
            .raw_i      (in_raw_i[i]),
            .db_o       (in_db_o[i]),
            .rise_o     (in_rise_o[i])
        );
    end

endmodule

// File: tb/tb_board_io_mux.sv
// Self-checking bench for board_io_mux: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count based reference model.
module tb_board_io_mux;

    localparam int NumOut = 20;
    localparam int NumIn  = 4;
    localparam int Db     = 8;
    localparam int Bp     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NumOut-1:0] gp = '0;
    logic [NumOut-1:0] pwm = '0;
    logic              cfg_we = 1'b0;
    logic [4:0]        cfg_idx = '0;
    logic [1:0]        cfg_mode = '0;
    logic [NumOut-1:0] pin;
    logic [NumIn-1:0]  in_raw = '0;
    logic [NumIn-1:0]  in_db;
    logic [NumIn-1:0]  in_rise;

    always #5 clk = ~clk;

    board_io_mux #(
        .NumOut         (NumOut),
        .NumIn          (NumIn),
        .DebounceCycles (Db),
        .BlinkPeriod    (Bp)
    ) dut (
        .clk_sys_i  (clk),
        .rst_sys_ni (rst_n),
        .gp_i       (gp),
        .pwm_i      (pwm),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_mode_i (cfg_mode),
        .pin_o      (pin),
        .in_raw_i   (in_raw),
        .in_db_o    (in_db),
        .in_rise_o  (in_rise)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: edges since reset, channel modes, accepted inputs and
    // the length of the current run of samples disagreeing with the accepted level.
    int                m_mode [NumOut];
    logic [NumOut-1:0] m_pin;
    int                m_k;
    logic [NumIn-1:0]  m_db, m_rise;
    int                m_run [NumIn];
    logic [NumIn-1:0]  m_hist [$];

    task automatic model_reset();
        for (int n = 0; n < NumOut; n++) m_mode[n] = 0;
        for (int i = 0; i < NumIn; i++) m_run[i] = 0;
        m_pin  = '0;
        m_k    = 0;
        m_db   = '0;
        m_rise = '0;
        m_hist.delete();
    endtask

    task automatic tick();
        logic [NumOut-1:0] pn;
        logic [NumIn-1:0]  seen;
        logic              blink_now;
        blink_now = ((m_k / Bp) % 2) == 1;
        for (int n = 0; n < NumOut; n++) begin
            case (m_mode[n])
                0:       pn[n] = gp[n];
                1:       pn[n] = pwm[n];
                2:       pn[n] = blink_now;
                default: pn[n] = 1'b0;
            endcase
        end
        if (cfg_we && int'(cfg_idx) < NumOut) m_mode[cfg_idx] = int'(cfg_mode);
        // Logic sees raw input as sampled two edges earlier.
        seen = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : '0;
        m_hist.push_back(in_raw);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        m_rise = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (seen[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == Db) begin
                    m_db[i]   = seen[i];
                    m_rise[i] = seen[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pin = pn;
        m_k++;
        @(posedge clk);
        #1;
        check_eq("pin", 32'(pin), 32'(m_pin));
        check_eq("db", 32'(in_db), 32'(m_db));
        check_eq("rise", 32'(in_rise), 32'(m_rise));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_pin", 32'(pin), 32'd0);
        check_eq("rst_db", 32'(in_db), 32'd0);
        check_eq("rst_rise", 32'(in_rise), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int idx, input int mode);
        cfg_we   = 1'b1;
        cfg_idx  = 5'(idx);
        cfg_mode = 2'(mode);
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int last, gap_ok, toggles, first, rises;
        logic prev;
        logic [NumOut-1:0] snap;
        model_reset();
        #12;
        check_eq("por_pin", 32'(pin), 32'd0);
        check_eq("por_db", 32'(in_db), 32'd0);
        rst_n = 1'b1;
        gp    = '1;
        check_eq("rel_pin0", 32'(pin), 32'd0);
        tick();
        check_eq("rel_pin1", 32'(pin), 32'hFFFFF);

        // Channel 3 to PWM; still shows gp on the write edge.
        pwm = '0;
        cfg_write(3, 1);
        check_eq("pwm_wr_edge", 32'(pin[3]), 32'd1);
        tick();
        check_eq("pwm_next_edge", 32'(pin[3]), 32'd0);
        snap = pin;
        cfg_write(25, 3);
        tick();
        tick();
        check_eq("idx25_ignored", 32'(pin), 32'(snap));

        // Channel 0 blink: toggles every Bp cycles.
        cfg_write(0, 2);
        last = -1; gap_ok = 1; toggles = 0; prev = pin[0];
        for (int t = 0; t < 20; t++) begin
            tick();
            if (pin[0] != prev) begin
                if (last >= 0 && t - last != Bp) gap_ok = 0;
                last = t;
                toggles++;
            end
            prev = pin[0];
        end
        check_eq("blink_gap", 32'(gap_ok), 32'd1);
        check_eq("blink_toggles", 32'(toggles >= 4), 32'd1);
        cfg_write(0, 3);
        tick();
        check_eq("off_pin0", 32'(pin[0]), 32'd0);

        // Glitch of Db-1 cycles on input 0.
        in_raw[0] = 1'b1;
        rises = 0; first = 0;
        for (int t = 0; t < 7; t++) begin
            tick();
            rises += int'(in_rise[0]);
            first |= int'(in_db[0]);
        end
        in_raw[0] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            rises += int'(in_rise[0]);
            first |= int'(in_db[0]);
        end
        check_eq("glitch_db", 32'(first), 32'd0);
        check_eq("glitch_rise", 32'(rises), 32'd0);

        // Held input 1: accepted after 2 sync + Db cycles, one rise pulse.
        in_raw[1] = 1'b1;
        first = 0; rises = 0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            rises += int'(in_rise[1]);
            if (in_db[1] && first == 0) first = t;
        end
        check_eq("db1_latency", 32'(first), 32'd10);
        check_eq("db1_rises", 32'(rises), 32'd1);
        in_raw[1] = 1'b0;
        rises = 0;
        for (int t = 0; t < 14; t++) begin
            tick();
            rises += int'(in_rise[1]);
        end
        check_eq("db1_fall", 32'(in_db[1]), 32'd0);
        check_eq("db1_fall_rise", 32'(rises), 32'd0);

        // Reset during a partial count on input 2.
        in_raw[2] = 1'b1;
        for (int t = 0; t < 7; t++) tick();
        do_reset();
        first = 0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (in_db[2] && first == 0) first = t;
        end
        check_eq("rst_restart_latency", 32'(first), 32'd10);

        // Randomized traffic.
        for (int t = 0; t < 1500; t++) begin
            gp  = NumOut'($urandom);
            pwm = NumOut'($urandom);
            for (int i = 0; i < NumIn; i++) begin
                if ($urandom_range(0, 15) == 0) in_raw[i] = ~in_raw[i];
            end
            if ($urandom_range(0, 7) == 0) begin
                cfg_we   = 1'b1;
                cfg_idx  = 5'($urandom_range(0, 31));
                cfg_mode = 2'($urandom);
            end else begin
                cfg_we = 1'b0;
            end
            tick();
            if (t == 900) do_reset();
        end
        cfg_we = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
